// File: rtl/data_access_unit_if.sv
// Data-access unit bus bundle.
// Groups the decoder request/response handshake and the memory_map access signals.
//   slave  : the data_access_unit side (takes requests, drives memory_map and responses)
//   master : the environment side (decoder + memory_map)
// Signals:
//   req_valid/req_ready/req_op/req_store/req_ptr/req_imm/req_wdata : decoder request
//   mm_addr/mm_we/mm_io_only/mm_wdata/mm_rdata                     : memory_map access
//   rsp_valid/rsp_rdata/ptr_wb_en/ptr_wb_val                       : completion + pointer writeback
//   sp_out                                                         : current stack pointer
interface data_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_store;
    logic [15:0] req_ptr;
    logic [15:0] req_imm;
    logic [7:0]  req_wdata;
    logic [15:0] mm_addr;
    logic        mm_we;
    logic        mm_io_only;
    logic [7:0]  mm_wdata;
    logic [7:0]  mm_rdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ptr_wb_en;
    logic [15:0] ptr_wb_val;
    logic [15:0] sp_out;

    modport slave (
        input  req_valid, req_op, req_store, req_ptr, req_imm, req_wdata, mm_rdata,
        output req_ready, mm_addr, mm_we, mm_io_only, mm_wdata,
        output rsp_valid, rsp_rdata, ptr_wb_en, ptr_wb_val, sp_out
    );

    modport master (
        output req_valid, req_op, req_store, req_ptr, req_imm, req_wdata, mm_rdata,
        input  req_ready, mm_addr, mm_we, mm_io_only, mm_wdata,
        input  rsp_valid, rsp_rdata, ptr_wb_en, ptr_wb_val, sp_out
    );
endinterface

// File: rtl/data_access_unit.sv
// Data-access unit: sequences LD/ST, LDS/STS, PUSH/POP and IN/OUT into memory_map.
// One request at a time: IDLE -> ACCESS -> (loads: CAPTURE) -> RESP -> IDLE.
// Ports:
//   clk    : system clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : data_access_unit_if.slave (request, memory_map access, response, sp_out)
// Store latency: rsp_valid two cycles after the accept edge; loads: three cycles.
module data_access_unit #(
    parameter logic [15:0] RAMEND = 16'h085F
) (
    input logic               clk,
    input logic               rst_n,
    data_access_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

    localparam logic [2:0] OpPtr     = 3'd0;
    localparam logic [2:0] OpPostInc = 3'd1;
    localparam logic [2:0] OpPreDec  = 3'd2;
    localparam logic [2:0] OpDisp    = 3'd3;
    localparam logic [2:0] OpDirect  = 3'd4;
    localparam logic [2:0] OpPush    = 3'd5;
    localparam logic [2:0] OpPop     = 3'd6;
    localparam logic [2:0] OpIo      = 3'd7;

    state_e      state_q;
    logic        store_q;
    logic        wb_en_q;
    logic [15:0] wb_val_q;
    logic        sp_upd_q;
    logic [15:0] sp_new_q;
    logic [15:0] sp_q;

    // Decode of the incoming request; only consumed on the accept edge.
    logic [15:0] ea;
    logic [15:0] wb_val;
    logic [15:0] sp_new;
    logic        store;
    logic        io;
    logic        wb_en;
    logic        sp_upd;

    always_comb begin
        ea     = bus.req_ptr;
        wb_val = bus.req_ptr;
        sp_new = sp_q;
        store  = bus.req_store;
        io     = 1'b0;
        wb_en  = 1'b0;
        sp_upd = 1'b0;
        unique case (bus.req_op)
            OpPtr:     ea = bus.req_ptr;
            OpPostInc: begin
                ea     = bus.req_ptr;
                wb_val = bus.req_ptr + 16'd1;
                wb_en  = 1'b1;
            end
            OpPreDec:  begin
                ea     = bus.req_ptr - 16'd1;
                wb_val = bus.req_ptr - 16'd1;
                wb_en  = 1'b1;
            end
            OpDisp:    ea = bus.req_ptr + {10'b0, bus.req_imm[5:0]};
            OpDirect:  ea = bus.req_imm;
            OpPush:    begin
                // Post-decrement stack: write at sp, then sp-1.
                ea     = sp_q;
                store  = 1'b1;
                sp_upd = 1'b1;
                sp_new = sp_q - 16'd1;
            end
            OpPop:     begin
                // Pre-increment stack: read at sp+1, which becomes the new sp.
                ea     = sp_q + 16'd1;
                store  = 1'b0;
                sp_upd = 1'b1;
                sp_new = sp_q + 16'd1;
            end
            OpIo:      begin
                ea = {10'b0, bus.req_imm[5:0]};
                io = 1'b1;
            end
        endcase
    end

    assign bus.sp_out = sp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            store_q        <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_val_q       <= '0;
            sp_upd_q       <= 1'b0;
            sp_new_q       <= RAMEND;
            sp_q           <= RAMEND;
            bus.req_ready  <= 1'b1;
            bus.mm_addr    <= '0;
            bus.mm_we      <= 1'b0;
            bus.mm_io_only <= 1'b0;
            bus.mm_wdata   <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.ptr_wb_en  <= 1'b0;
            bus.ptr_wb_val <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.ptr_wb_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        state_q        <= StAccess;
                        bus.req_ready  <= 1'b0;
                        store_q        <= store;
                        wb_en_q        <= wb_en;
                        wb_val_q       <= wb_val;
                        sp_upd_q       <= sp_upd;
                        sp_new_q       <= sp_new;
                        bus.mm_addr    <= ea;
                        bus.mm_we      <= store;
                        bus.mm_io_only <= io;
                        bus.mm_wdata   <= store ? bus.req_wdata : 8'h00;
                    end
                end
                StAccess: begin
                    bus.mm_we    <= 1'b0;
                    bus.mm_wdata <= 8'h00;
                    if (store_q) begin
                        state_q        <= StResp;
                        bus.mm_io_only <= 1'b0;
                        bus.rsp_valid  <= 1'b1;
                        bus.ptr_wb_en  <= wb_en_q;
                        if (wb_en_q) bus.ptr_wb_val <= wb_val_q;
                        if (sp_upd_q) sp_q <= sp_new_q;
                    end else begin
                        // Read data from memory_map is registered: it lands during CAPTURE.
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    state_q        <= StResp;
                    bus.mm_io_only <= 1'b0;
                    bus.rsp_rdata  <= bus.mm_rdata;
                    bus.rsp_valid  <= 1'b1;
                    bus.ptr_wb_en  <= wb_en_q;
                    if (wb_en_q) bus.ptr_wb_val <= wb_val_q;
                    if (sp_upd_q) sp_q <= sp_new_q;
                end
                StResp: begin
                    state_q       <= StIdle;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_access_unit.sv
// Bench for data_access_unit: a memory_map stand-in, a transaction-level reference model,
// one per-cycle compare process, directed scenarios with literal expectations, random traffic.
module tb_data_access_unit;
    localparam logic [15:0] RAMEND = 16'h085F;

    logic clk;
    logic rst_n;
    data_access_unit_if bus ();

    data_access_unit #(.RAMEND(RAMEND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // memory_map stand-in: registered read, write on mm_we.
    logic [7:0] mem     [65536];
    logic [7:0] ref_mem [65536];

    always @(posedge clk) begin
        if (bus.mm_we) mem[bus.mm_addr] <= bus.mm_wdata;
        bus.mm_rdata <= mem[bus.mm_addr];
    end

    // Transaction-level model: one request in flight, outputs derived from the
    // cycle offset s since the accept edge (s=1 is the address cycle).
    typedef struct packed {
        int          a;
        int          lat;
        logic [15:0] ea;
        logic        store;
        logic        io;
        logic        wb_en;
        logic [15:0] wb_val;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [15:0] sp_before;
    } txn_t;

    txn_t        t;
    bit          have_txn;
    int          cyc = 0;
    int          n_acc = 0;
    int          acc_prev = 0;
    int          acc_last = 0;
    logic [15:0] m_sp;
    logic [15:0] last_ea;
    logic [7:0]  last_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_txn   = 1'b0;
            m_sp       = RAMEND;
            last_ea    = 16'h0000;
            last_rdata = 8'h00;
        end else begin
            bit          rdy;
            int          s;
            logic [2:0]  op;
            logic [15:0] p;
            logic [15:0] im;
            logic [15:0] ea;
            logic [15:0] spa;
            rdy = !have_txn || (cyc - t.a + 1 > t.lat);
            cyc++;
            if (have_txn) begin
                s = cyc - t.a + 1;
                if (s == 2 && t.store) ref_mem[t.ea] = t.wdata;
                if (s == t.lat && !t.store) last_rdata = t.rdata;
            end
            if (rdy && bus.req_valid) begin
                op = bus.req_op;
                p  = bus.req_ptr;
                im = bus.req_imm;
                t.store  = (op == 3'd5) ? 1'b1 : (op == 3'd6) ? 1'b0 : bus.req_store;
                t.io     = (op == 3'd7);
                t.wb_en  = (op == 3'd1) || (op == 3'd2);
                t.wb_val = (op == 3'd1) ? p + 16'd1 : p - 16'd1;
                spa      = m_sp;
                case (op)
                    3'd0, 3'd1: ea = p;
                    3'd2:       ea = p - 16'd1;
                    3'd3:       ea = p + 16'(im[5:0]);
                    3'd4:       ea = im;
                    3'd5: begin ea = m_sp;         spa = m_sp - 16'd1; end
                    3'd6: begin ea = m_sp + 16'd1; spa = ea;           end
                    default:    ea = 16'(im[5:0]);
                endcase
                t.a         = cyc;
                t.lat       = t.store ? 2 : 3;
                t.ea        = ea;
                t.wdata     = bus.req_wdata;
                t.rdata     = ref_mem[ea];
                t.sp_before = m_sp;
                m_sp        = spa;
                last_ea     = ea;
                have_txn    = 1'b1;
                acc_prev    = acc_last;
                acc_last    = cyc;
                n_acc++;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            int s;
            bit in_t;
            s    = have_txn ? cyc - t.a + 1 : 0;
            in_t = have_txn && s >= 1 && s <= t.lat;
            chk("req_ready", bus.req_ready, !in_t);
            chk("mm_we", bus.mm_we, in_t && s == 1 && t.store);
            if (in_t && s == 1) chk("mm_io_only", bus.mm_io_only, t.io);
            else if (!(in_t && !t.store && s == 2)) chk("mm_io_only_idle", bus.mm_io_only, 0);
            chk("mm_addr", bus.mm_addr, last_ea);
            if (in_t && s == 1 && t.store) chk("mm_wdata", bus.mm_wdata, t.wdata);
            chk("rsp_valid", bus.rsp_valid, in_t && s == t.lat);
            chk("ptr_wb_en", bus.ptr_wb_en, in_t && s == t.lat && t.wb_en);
            if (in_t && s == t.lat && t.wb_en) chk("ptr_wb_val", bus.ptr_wb_val, t.wb_val);
            chk("rsp_rdata", bus.rsp_rdata, last_rdata);
            chk("sp_out", bus.sp_out, (in_t && s < t.lat) ? t.sp_before : m_sp);
        end
    end

    // Drive a request and return #1 after its accept edge (inside the address cycle).
    task automatic issue(input logic [2:0] op, input logic st, input logic [15:0] ptr,
                         input logic [15:0] imm, input logic [7:0] wd);
        int base;
        base          = n_acc;
        bus.req_op    = op;
        bus.req_store = st;
        bus.req_ptr   = ptr;
        bus.req_imm   = imm;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 40 && n_acc == base; i++) begin
            @(posedge clk);
            #1;
        end
        if (n_acc == base) chk("accept_timeout", n_acc - base, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8);
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0;
        bus.req_store = 1'b0;
        bus.req_ptr = 16'h0;
        bus.req_imm = 16'h0;
        bus.req_wdata = 8'h0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_sp", bus.sp_out, 16'h085F);
        chk("reset_addr", bus.mm_addr, 16'h0000);

        // PUSH 0x11 then POP.
        issue(3'd5, 1'b0, 16'h0, 16'h0, 8'h11);
        @(negedge clk);
        chk("push_addr", bus.mm_addr, 16'h085F);
        chk("push_we", bus.mm_we, 1);
        @(negedge clk);
        chk("push_sp", bus.sp_out, 16'h085E);
        issue(3'd6, 1'b0, 16'h0, 16'h0, 8'h00);
        @(negedge clk);
        chk("pop_addr", bus.mm_addr, 16'h085F);
        repeat (2) @(negedge clk);
        chk("pop_rdata", bus.rsp_rdata, 8'h11);
        chk("pop_sp", bus.sp_out, 16'h085F);

        // Store POSTINC.
        issue(3'd1, 1'b1, 16'h0100, 16'h0, 8'hA5);
        @(negedge clk);
        chk("pinc_addr", bus.mm_addr, 16'h0100);
        chk("pinc_we", bus.mm_we, 1);
        chk("pinc_wdata", bus.mm_wdata, 8'hA5);
        @(negedge clk);
        chk("pinc_rsp", bus.rsp_valid, 1);
        chk("pinc_wb_en", bus.ptr_wb_en, 1);
        chk("pinc_wb_val", bus.ptr_wb_val, 16'h0101);

        // Load PREDEC from 0x0000 wraps to 0xFFFF.
        mem[16'hFFFF] = 8'h3C;
        ref_mem[16'hFFFF] = 8'h3C;
        issue(3'd2, 1'b0, 16'h0000, 16'h0, 8'h00);
        @(negedge clk);
        chk("pdec_addr", bus.mm_addr, 16'hFFFF);
        repeat (2) @(negedge clk);
        chk("pdec_rsp", bus.rsp_valid, 1);
        chk("pdec_rdata", bus.rsp_rdata, 8'h3C);
        chk("pdec_wb_val", bus.ptr_wb_val, 16'hFFFF);

        // IN with upper imm bits set; DISP with q=63.
        issue(3'd7, 1'b0, 16'h1234, 16'hABFF, 8'h00);
        @(negedge clk);
        chk("io_addr", bus.mm_addr, 16'h003F);
        chk("io_flag", bus.mm_io_only, 1);
        chk("io_we", bus.mm_we, 0);
        wait_idle();
        issue(3'd3, 1'b0, 16'h0200, 16'h003F, 8'h00);
        @(negedge clk);
        chk("disp_addr", bus.mm_addr, 16'h023F);
        repeat (2) @(negedge clk);
        chk("disp_rsp", bus.rsp_valid, 1);
        chk("disp_wb_en", bus.ptr_wb_en, 0);

        // Request held valid through a load.
        wait_idle();
        bus.req_op = 3'd4;
        bus.req_store = 1'b0;
        bus.req_imm = 16'h0040;
        bus.req_valid = 1'b1;
        base = n_acc;
        for (int i = 0; i < 20 && n_acc < base + 2; i++) begin
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("hold_accepts", n_acc - base, 2);
        chk("hold_gap", acc_last - acc_prev, 4);

        // Reset in the middle of a store's address cycle.
        wait_idle();
        issue(3'd4, 1'b1, 16'h0, 16'h0123, 8'h77);
        chk("rst_we_before", bus.mm_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", bus.mm_we, 0);
        chk("rst_sp", bus.sp_out, 16'h085F);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_rsp", bus.rsp_valid, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Stack wrap: push down to 0, push once more, then pop at 0xFFFF.
        for (int i = 0; i < 16'h085F; i++) issue(3'd5, 1'b0, 16'h0, 16'h0, 8'(i));
        wait_idle();
        chk("wrap_sp0", bus.sp_out, 16'h0000);
        issue(3'd5, 1'b0, 16'h0, 16'h0, 8'h5A);
        @(negedge clk);
        chk("wrap_push_addr", bus.mm_addr, 16'h0000);
        @(negedge clk);
        chk("wrap_push_sp", bus.sp_out, 16'hFFFF);
        issue(3'd6, 1'b0, 16'h0, 16'h0, 8'h00);
        @(negedge clk);
        chk("wrap_pop_addr", bus.mm_addr, 16'h0000);
        repeat (2) @(negedge clk);
        chk("wrap_pop_rdata", bus.rsp_rdata, 8'h5A);
        chk("wrap_pop_sp", bus.sp_out, 16'h0000);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 16'($urandom),
                  8'($urandom));
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
